// File: rtl/spi_flash_xip_pkg.sv
// Shared constants and types for the SPI flash execute-in-place read controller.
package spi_flash_xip_pkg;

  localparam logic [7:0] READ_OP   = 8'h03;
  localparam int         ADDR_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_HOLD = 3'd4,
    ST_CSH  = 3'd5
  } rd_state_t;

  // One-hot active-low chip select for a 2-bit device index.
  function automatic logic [3:0] cs_decode(input logic [1:0] idx);
    cs_decode = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/spi_flash_sck_gen.sv
// SCK divider: SPI mode 0 clock that idles low; strobes flag the clk edge on which SCK toggles.
module spi_flash_sck_gen #(
  parameter int SCK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic pause,
  output logic sck,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  logic [CW-1:0] cnt_r;
  logic          sck_r;
  logic          wrap_s;

  assign wrap_s     = run && !pause && (cnt_r == CW'(SCK_DIV - 1));
  assign rise_pulse = wrap_s && !sck_r;
  assign fall_pulse = wrap_s && sck_r;
  assign sck        = sck_r;

  // Half-period counter; stopping the link clears it so every bit starts with a full low phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
      sck_r <= 1'b0;
    end else if (!run) begin
      cnt_r <= '0;
      sck_r <= 1'b0;
    end else if (pause) begin
      cnt_r <= cnt_r;
      sck_r <= sck_r;
    end else if (wrap_s) begin
      cnt_r <= '0;
      sck_r <= !sck_r;
    end else begin
      cnt_r <= cnt_r + CW'(1);
      sck_r <= sck_r;
    end
  end

endmodule

// File: rtl/spi_flash_xip.sv
// AXI4 read-only XIP bridge: each AR burst becomes one SPI READ (0x03); writes are answered SLVERR.
module spi_flash_xip
  import spi_flash_xip_pkg::*;
#(
  parameter int DW      = 128,
  parameter int AW      = 32,
  parameter int IDW     = 8,
  parameter int SCK_DIV = 2,
  parameter int CSH_MIN = 2
) (
  input  logic            spi_flash_aclk,
  input  logic            spi_flash_aresetn,
  input  logic [IDW-1:0]  spi_flash_awid,
  input  logic [AW-1:0]   spi_flash_awaddr,
  input  logic [7:0]      spi_flash_awlen,
  input  logic [2:0]      spi_flash_awsize,
  input  logic [1:0]      spi_flash_awburst,
  input  logic            spi_flash_awlock,
  input  logic [2:0]      spi_flash_awcache,
  input  logic            spi_flash_awvalid,
  output logic            spi_flash_awready,
  input  logic [DW-1:0]   spi_flash_wdata,
  input  logic [DW/8-1:0] spi_flash_wstrb,
  input  logic            spi_flash_wlast,
  input  logic            spi_flash_wvalid,
  output logic            spi_flash_wready,
  output logic [IDW-1:0]  spi_flash_bid,
  output logic [1:0]      spi_flash_bresp,
  output logic            spi_flash_bvalid,
  input  logic            spi_flash_bready,
  input  logic [IDW-1:0]  spi_flash_arid,
  input  logic [AW-1:0]   spi_flash_araddr,
  input  logic [7:0]      spi_flash_arlen,
  input  logic [2:0]      spi_flash_arsize,
  input  logic [1:0]      spi_flash_arburst,
  input  logic            spi_flash_arvalid,
  output logic            spi_flash_arready,
  output logic [IDW-1:0]  spi_flash_rid,
  output logic [DW-1:0]   spi_flash_rdata,
  output logic [1:0]      spi_flash_rresp,
  output logic            spi_flash_rlast,
  output logic            spi_flash_rvalid,
  input  logic            spi_flash_rready,
  output logic [3:0]      spi_flash_csen,
  output logic [3:0]      spi_flash_csn_o,
  input  logic [3:0]      spi_flash_csn_i,
  output logic            spi_flash_sdo_en,
  output logic            spi_flash_sdo_o,
  input  logic            spi_flash_sdo_i,
  output logic            spi_flash_sdi_en,
  output logic            spi_flash_sdi_o,
  input  logic            spi_flash_sdi_i,
  output logic            spi_flash_sck,
  output logic            spi_flash_busy
);

  localparam int BCW     = $clog2(DW + 32);
  localparam int LBW     = $clog2(DW);
  localparam int CSH_LEN = CSH_MIN * 2 * SCK_DIV;
  localparam int CSHW    = $clog2(CSH_LEN + 1);
  localparam logic [ADDR_BITS-1:0] BEAT_MASK = ADDR_BITS'(DW / 8 - 1);

  rd_state_t         state_r;
  logic              arready_r, cs_act_r, sdo_r, rvalid_r, rlast_r;
  logic [3:0]        csn_r;
  logic [1:0]        cs_sel_r;
  logic [31:0]       tx_r;
  logic [DW-1:0]     rx_r, rdata_r;
  logic [IDW-1:0]    rid_r, bid_r;
  logic [7:0]        len_r, beat_r;
  logic [BCW-1:0]    bit_cnt_r;
  logic [CSHW-1:0]   csh_cnt_r;
  logic              awready_r, aw_held_r, wready_r, bvalid_r;
  logic              run_s, pause_s, rise_s, fall_s;
  logic [LBW-1:0]    rx_idx_s;
  logic              unused_s;

  // SCK only runs once CS is down; HOLD freezes it low mid-burst.
  assign run_s   = cs_act_r && (state_r == ST_CMD || state_r == ST_ADDR ||
                                state_r == ST_DATA || state_r == ST_HOLD);
  assign pause_s = (state_r == ST_HOLD);
  // Bytes arrive MSB-first and fill lanes from lane 0 upward.
  assign rx_idx_s = bit_cnt_r[LBW-1:0] ^ LBW'(7);

  spi_flash_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
    .clk        (spi_flash_aclk),
    .rst_n      (spi_flash_aresetn),
    .run        (run_s),
    .pause      (pause_s),
    .sck        (spi_flash_sck),
    .rise_pulse (rise_s),
    .fall_pulse (fall_s)
  );

  // Read FSM: command/address shift-out, per-beat data shift-in, R hold and CS high time.
  always_ff @(posedge spi_flash_aclk or negedge spi_flash_aresetn) begin
    if (!spi_flash_aresetn) begin
      state_r <= ST_IDLE;   arready_r <= 1'b1;  cs_act_r <= 1'b0;   csn_r   <= 4'hF;
      sdo_r   <= 1'b0;      rvalid_r  <= 1'b0;  rlast_r  <= 1'b0;   cs_sel_r <= 2'd0;
      tx_r    <= '0;        rx_r      <= '0;    rdata_r  <= '0;     rid_r   <= '0;
      len_r   <= 8'd0;      beat_r    <= 8'd0;  bit_cnt_r <= '0;    csh_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (spi_flash_arvalid && arready_r) begin
            state_r   <= ST_CMD;
            arready_r <= 1'b0;
            cs_act_r  <= 1'b0;
            rid_r     <= spi_flash_arid;
            len_r     <= spi_flash_arlen;
            beat_r    <= 8'd0;
            cs_sel_r  <= spi_flash_araddr[25:24];
            tx_r      <= {READ_OP, spi_flash_araddr[ADDR_BITS-1:0] & ~BEAT_MASK};
            bit_cnt_r <= '0;
          end
        end
        ST_CMD, ST_ADDR: begin
          if (!cs_act_r) begin
            cs_act_r <= 1'b1;
            csn_r    <= cs_decode(cs_sel_r);
            sdo_r    <= tx_r[31];
          end else if (fall_s) begin
            tx_r <= tx_r << 1;
            if (bit_cnt_r == BCW'(31)) begin
              state_r   <= ST_DATA;
              bit_cnt_r <= '0;
              sdo_r     <= 1'b0;
            end else begin
              sdo_r     <= tx_r[30];
              bit_cnt_r <= bit_cnt_r + BCW'(1);
              if (bit_cnt_r == BCW'(7)) state_r <= ST_ADDR;
            end
          end
        end
        ST_DATA: begin
          if (rise_s) begin
            rx_r[rx_idx_s] <= spi_flash_sdi_i;
          end else if (fall_s) begin
            if (bit_cnt_r == BCW'(DW - 1)) begin
              state_r   <= ST_HOLD;
              bit_cnt_r <= '0;
              rdata_r   <= rx_r;
              rvalid_r  <= 1'b1;
              rlast_r   <= (beat_r == len_r);
            end else begin
              bit_cnt_r <= bit_cnt_r + BCW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (spi_flash_rready) begin
            rvalid_r <= 1'b0;
            rlast_r  <= 1'b0;
            if (rlast_r) begin
              state_r   <= ST_CSH;
              csn_r     <= 4'hF;
              cs_act_r  <= 1'b0;
              csh_cnt_r <= '0;
            end else begin
              state_r <= ST_DATA;
              beat_r  <= beat_r + 8'd1;
            end
          end
        end
        ST_CSH: begin
          if (csh_cnt_r == CSHW'(CSH_LEN - 1)) begin
            state_r   <= ST_IDLE;
            arready_r <= 1'b1;
          end else begin
            csh_cnt_r <= csh_cnt_r + CSHW'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          arready_r <= 1'b1;
          cs_act_r  <= 1'b0;
          csn_r     <= 4'hF;
        end
      endcase
    end
  end

  // Write path: accept one AW, swallow its W beats, answer SLVERR.
  always_ff @(posedge spi_flash_aclk or negedge spi_flash_aresetn) begin
    if (!spi_flash_aresetn) begin
      awready_r <= 1'b1;
      aw_held_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= '0;
    end else if (bvalid_r) begin
      if (spi_flash_bready) begin
        bvalid_r  <= 1'b0;
        aw_held_r <= 1'b0;
        awready_r <= 1'b1;
      end
    end else if (wready_r) begin
      if (spi_flash_wvalid && spi_flash_wlast) begin
        wready_r <= 1'b0;
        bvalid_r <= 1'b1;
      end
    end else if (awready_r && spi_flash_awvalid) begin
      awready_r <= 1'b0;
      aw_held_r <= 1'b1;
      wready_r  <= 1'b1;
      bid_r     <= spi_flash_awid;
    end
  end

  assign spi_flash_arready = arready_r;
  assign spi_flash_rid     = rid_r;
  assign spi_flash_rdata   = rdata_r;
  assign spi_flash_rresp   = 2'b00;
  assign spi_flash_rlast   = rlast_r;
  assign spi_flash_rvalid  = rvalid_r;
  assign spi_flash_awready = awready_r;
  assign spi_flash_wready  = wready_r;
  assign spi_flash_bid     = bid_r;
  assign spi_flash_bresp   = 2'b10;
  assign spi_flash_bvalid  = bvalid_r;
  assign spi_flash_csen    = 4'b1111;
  assign spi_flash_csn_o   = csn_r;
  assign spi_flash_sdo_en  = 1'b1;
  assign spi_flash_sdo_o   = sdo_r;
  assign spi_flash_sdi_en  = 1'b0;
  assign spi_flash_sdi_o   = 1'b0;
  assign spi_flash_busy    = (state_r != ST_IDLE) | aw_held_r | bvalid_r;

  assign unused_s = ^{spi_flash_awaddr, spi_flash_awlen, spi_flash_awsize, spi_flash_awburst,
                      spi_flash_awlock, spi_flash_awcache, spi_flash_wdata, spi_flash_wstrb,
                      spi_flash_arsize, spi_flash_arburst, spi_flash_araddr,
                      spi_flash_csn_i, spi_flash_sdo_i};

endmodule

// File: tb/tb_spi_flash_xip.sv
// Randomised bench for spi_flash_xip with a serial NOR model that returns byte = address[7:0].
module tb_spi_flash_xip;
  localparam int DW = 32, AW = 32, IDW = 8, SCK_DIV = 2, CSH_MIN = 2;
  localparam int FIRST_LAT = (32 + DW) * 2 * SCK_DIV + 1;
  localparam int BEAT_LAT  = DW * 2 * SCK_DIV;
  localparam int CSH_CLKS  = CSH_MIN * 2 * SCK_DIV;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [IDW-1:0] awid = '0, arid = '0, bid, rid;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0] awlen = 8'd0, arlen = 8'd0;
  logic [2:0] awsize = 3'd0, awcache = 3'd0, arsize = 3'd0;
  logic [1:0] awburst = 2'd0, arburst = 2'd0, bresp, rresp;
  logic awlock = 1'b0, awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rlast, rvalid;
  logic [DW-1:0] wdata = '0, rdata;
  logic [DW/8-1:0] wstrb = '0;
  logic [3:0] csen, csn;
  logic sdo_en, sdo, sdi_en, sdi_o, sck, busy;
  logic sdi = 1'b0;

  int total = 0, bad = 0, cyc = 0;

  spi_flash_xip #(.DW(DW), .AW(AW), .IDW(IDW), .SCK_DIV(SCK_DIV), .CSH_MIN(CSH_MIN)) dut (
    .spi_flash_aclk(clk), .spi_flash_aresetn(rst_n),
    .spi_flash_awid(awid), .spi_flash_awaddr(awaddr), .spi_flash_awlen(awlen),
    .spi_flash_awsize(awsize), .spi_flash_awburst(awburst), .spi_flash_awlock(awlock),
    .spi_flash_awcache(awcache), .spi_flash_awvalid(awvalid), .spi_flash_awready(awready),
    .spi_flash_wdata(wdata), .spi_flash_wstrb(wstrb), .spi_flash_wlast(wlast),
    .spi_flash_wvalid(wvalid), .spi_flash_wready(wready),
    .spi_flash_bid(bid), .spi_flash_bresp(bresp), .spi_flash_bvalid(bvalid), .spi_flash_bready(bready),
    .spi_flash_arid(arid), .spi_flash_araddr(araddr), .spi_flash_arlen(arlen),
    .spi_flash_arsize(arsize), .spi_flash_arburst(arburst), .spi_flash_arvalid(arvalid),
    .spi_flash_arready(arready), .spi_flash_rid(rid), .spi_flash_rdata(rdata),
    .spi_flash_rresp(rresp), .spi_flash_rlast(rlast), .spi_flash_rvalid(rvalid), .spi_flash_rready(rready),
    .spi_flash_csen(csen), .spi_flash_csn_o(csn), .spi_flash_csn_i(4'hF),
    .spi_flash_sdo_en(sdo_en), .spi_flash_sdo_o(sdo), .spi_flash_sdo_i(1'b0),
    .spi_flash_sdi_en(sdi_en), .spi_flash_sdi_o(sdi_o), .spi_flash_sdi_i(sdi),
    .spi_flash_sck(sck), .spi_flash_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial NOR model: 8-bit opcode + 24-bit address in on SCK rise, data out on SCK fall.
  logic [31:0] m_in = '0;
  logic [23:0] m_addr = '0, last_addr = '0;
  logic [7:0] last_op = 8'd0;
  logic m_sck = 1'b0;
  int m_rx = 0, m_bit = 0, sck_rises = 0;
  always @(sck or csn) begin
    if (csn == 4'hF) begin
      m_rx = 0; m_bit = 0; sdi = 1'b0;
    end else if (sck && !m_sck) begin
      sck_rises++;
      if (m_rx < 32) begin
        m_in = {m_in[30:0], sdo};
        m_rx++;
        if (m_rx == 32) begin
          last_op = m_in[31:24]; last_addr = m_in[23:0]; m_addr = m_in[23:0]; m_bit = 0;
        end
      end
    end else if (!sck && m_sck && m_rx == 32) begin
      sdi = m_addr[7 - m_bit];
      if (m_bit == 7) begin m_bit = 0; m_addr = m_addr + 24'd1; end
      else m_bit++;
    end
    m_sck = sck;
  end

  // Length of the most recent run of all chip selects high.
  int hi_run = 0, last_gap = 0;
  always @(negedge clk) begin
    if (csn == 4'hF) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0) last_gap <= hi_run;
      hi_run <= 0;
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [IDW-1:0] id,
                            input int hold_beat, input int hold_clks);
    int hs, t, to, rises, cs_bad, stable_bad;
    logic [23:0] fa, ba;
    logic [3:0] ecs;
    logic [DW-1:0] expd, snap;
    fa  = addr[23:0] & ~24'(DW / 8 - 1);
    ecs = ~(4'b0001 << addr[25:24]);
    araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
    arsize = 3'($urandom_range(0, 7)); arburst = 2'($urandom_range(0, 3));
    to = 0;
    while (!arready && to < 1000) begin @(negedge clk); to++; end
    @(posedge clk); @(negedge clk);
    hs = cyc; arvalid = 1'b0;
    cs_bad = 0;
    for (int b = 0; b <= int'(len); b++) begin
      rready = (b == hold_beat) ? 1'b0 : 1'b1;
      t = 0;
      while (!rvalid && t < 4 * FIRST_LAT) begin
        if (csn !== ecs && !(b == 0 && t == 0)) cs_bad++;
        @(negedge clk); t++;
      end
      total++;
      if ((cyc - hs) != ((b == 0) ? FIRST_LAT : BEAT_LAT)) begin
        bad++; $display("FAIL latency beat %0d: got %0d want %0d", b, cyc - hs, (b == 0) ? FIRST_LAT : BEAT_LAT);
      end
      expd = '0;
      for (int k = 0; k < DW / 8; k++) begin
        ba = fa + 24'(b * (DW / 8) + k);
        expd[8*k +: 8] = ba[7:0];
      end
      total++;
      if (rdata !== expd) begin bad++; $display("FAIL rdata beat %0d: got %h want %h", b, rdata, expd); end
      total++;
      if (rlast !== (b == int'(len))) begin bad++; $display("FAIL rlast beat %0d: got %b want %b", b, rlast, b == int'(len)); end
      total++;
      if (rid !== id || rresp !== 2'b00) begin bad++; $display("FAIL rid/rresp: got %h/%b want %h/00", rid, rresp, id); end
      total++;
      if (csn !== ecs || busy !== 1'b1) begin bad++; $display("FAIL cs/busy at beat: got %b/%b want %b/1", csn, busy, ecs); end
      if (b == 0) begin
        total++;
        if (last_op !== 8'h03 || last_addr !== fa) begin
          bad++; $display("FAIL mosi: got op %h addr %h want op 03 addr %h", last_op, last_addr, fa);
        end
      end
      if (b == hold_beat) begin
        snap = rdata; rises = sck_rises; stable_bad = 0;
        repeat (hold_clks) begin
          @(negedge clk);
          if (sck !== 1'b0 || rdata !== snap || rvalid !== 1'b1) stable_bad++;
        end
        total++;
        if (stable_bad != 0 || sck_rises != rises) begin
          bad++; $display("FAIL hold: got %0d unstable clks, %0d sck edges want 0/0", stable_bad, sck_rises - rises);
        end
        rready = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      hs = cyc;
    end
    total++;
    if (cs_bad != 0) begin bad++; $display("FAIL cs_held_low: got %0d bad clks want 0", cs_bad); end
    total++;
    if (csn !== 4'hF || rvalid !== 1'b0 || arready !== 1'b0) begin
      bad++; $display("FAIL burst_end: got csn %b rvalid %b arready %b want 1111/0/0", csn, rvalid, arready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (csn !== 4'hF || sck !== 1'b0 || sdo !== 1'b0 || arready !== 1'b1 || awready !== 1'b1 ||
        wready !== 1'b0 || rvalid !== 1'b0 || bvalid !== 1'b0 || rlast !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset: got csn %b sck %b sdo %b ar %b aw %b w %b r %b b %b last %b busy %b",
                      csn, sck, sdo, arready, awready, wready, rvalid, bvalid, rlast, busy);
    end
    total++;
    if (csen !== 4'hF || sdo_en !== 1'b1 || sdi_en !== 1'b0 || sdi_o !== 1'b0) begin
      bad++; $display("FAIL pad_consts: got %b %b %b %b want 1111 1 0 0", csen, sdo_en, sdi_en, sdi_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    read_burst(32'h0100_0010, 8'd0, 8'h5A, -1, 0);
    total++;
    if (last_addr !== 24'h000010) begin bad++; $display("FAIL single_addr: got %h want 000010", last_addr); end
  endtask

  task automatic test_burst();
    read_burst({6'd0, 2'($urandom_range(0, 3)), 24'($urandom)}, 8'd3, 8'($urandom), -1, 0);
  endtask

  task automatic test_backpressure();
    read_burst({6'd0, 2'($urandom_range(0, 3)), 24'($urandom)}, 8'd2, 8'($urandom), 1, 50);
  endtask

  task automatic test_back_to_back();
    read_burst({6'd0, 2'd2, 24'($urandom)}, 8'd1, 8'h11, -1, 0);
    read_burst({6'd0, 2'd3, 24'($urandom)}, 8'd0, 8'h22, -1, 0);
    total++;
    if (last_gap < CSH_CLKS) begin bad++; $display("FAIL cs_gap: got %0d clks want >= %0d", last_gap, CSH_CLKS); end
  endtask

  task automatic do_write(input logic [IDW-1:0] id, input int nbeats);
    int to, sent;
    repeat (20) @(negedge clk);
    awid = id; awaddr = $urandom; awlen = 8'(nbeats - 1); awvalid = 1'b1;
    wvalid = 1'b1; wdata = $urandom; wlast = 1'b0;
    total++;
    if (wready !== 1'b0) begin bad++; $display("FAIL wready_before_aw: got %b want 0", wready); end
    to = 0;
    while (!awready && to < 100) begin @(negedge clk); to++; end
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    total++;
    if (wready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL aw_accept: got wready %b busy %b want 1/1", wready, busy); end
    sent = 0; to = 0;
    while (sent < nbeats && to < 200) begin
      wlast = (sent == nbeats - 1); wdata = $urandom;
      if (wready) begin @(posedge clk); @(negedge clk); sent++; end
      else begin @(negedge clk); to++; end
    end
    wvalid = 1'b0; wlast = 1'b0;
    to = 0;
    while (!bvalid && to < 100) begin @(negedge clk); to++; end
    repeat (3) @(negedge clk);
    total++;
    if (bvalid !== 1'b1 || bresp !== 2'b10 || bid !== id || wready !== 1'b0 || awready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL bresp: got bvalid %b bresp %b bid %h wready %b awready %b busy %b want 1/10/%h/0/0/1",
                      bvalid, bresp, bid, wready, awready, busy, id);
    end
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    total++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin bad++; $display("FAIL b_done: got bvalid %b awready %b want 0/1", bvalid, awready); end
  endtask

  task automatic test_write_during_read();
    logic [IDW-1:0] wid;
    wid = 8'($urandom);
    fork
      read_burst({6'd0, 2'($urandom_range(0, 3)), 24'($urandom)}, 8'd2, 8'($urandom), -1, 0);
      do_write(wid, 3);
    join
    repeat (CSH_CLKS + 2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_addr();
    logic [31:0] addr;
    int to;
    addr = {6'd0, 2'd0, 24'($urandom)};
    araddr = addr; arlen = 8'd1; arid = 8'h33; arvalid = 1'b1;
    to = 0;
    while (!arready && to < 1000) begin @(negedge clk); to++; end
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    repeat (60) @(negedge clk);
    total++;
    if (csn !== 4'b1110) begin bad++; $display("FAIL pre_reset_cs: got %b want 1110", csn); end
    rst_n = 1'b0;
    #1;
    total++;
    if (csn !== 4'hF || sck !== 1'b0 || sdo !== 1'b0 || arready !== 1'b1 || rvalid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_abort: got csn %b sck %b sdo %b arready %b rvalid %b busy %b", csn, sck, sdo, arready, rvalid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_burst({6'd0, 2'($urandom_range(0, 3)), 24'($urandom)}, 8'd1, 8'($urandom), -1, 0);
  endtask

  task automatic test_random_bursts();
    for (int i = 0; i < 3; i++) begin
      read_burst($urandom & 32'h03FF_FFFF, 8'($urandom_range(0, 2)), 8'($urandom),
                 $urandom_range(0, 2), $urandom_range(1, 20));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_back_to_back();
    test_write_during_read();
    test_reset_mid_addr();
    test_random_bursts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
